// File: rtl/value_display_pkg.sv
// value_display_pkg: display codes, glyph constants and FSM state encodings shared by value_display.
package value_display_pkg;
  localparam logic [3:0] CODE_CORRECT = 4'd10;
  localparam logic [3:0] CODE_WRONG = 4'd11;
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_U = 7'h3E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;
  localparam logic [1:0] ST_SHOW = 2'd0;
  localparam logic [1:0] ST_RES_ON = 2'd1;
  localparam logic [1:0] ST_RES_OFF = 2'd2;
  function automatic logic is_result(input logic [3:0] code);
    return code == CODE_CORRECT || code == CODE_WRONG;
  endfunction
endpackage

// File: rtl/value_display_seg_glyph_rom.sv
// seg_glyph_rom: active-high 7-segment glyph {g,f,e,d,c,b,a} for a 4-bit display code.
module seg_glyph_rom
  import value_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph
);
  always_comb begin
    case (code)
      4'd0: glyph = GLYPH_0;
      4'd1: glyph = GLYPH_1;
      4'd2: glyph = GLYPH_2;
      4'd3: glyph = GLYPH_3;
      4'd4: glyph = GLYPH_4;
      4'd5: glyph = GLYPH_5;
      4'd6: glyph = GLYPH_6;
      4'd7: glyph = GLYPH_7;
      4'd8: glyph = GLYPH_8;
      4'd9: glyph = GLYPH_9;
      CODE_CORRECT: glyph = GLYPH_U;
      CODE_WRONG: glyph = GLYPH_E;
      default: glyph = GLYPH_BLANK;
    endcase
  end
endmodule

// File: rtl/value_display.sv
// value_display: digit/result display with blinking results; VALUE_DISPLAY_STREAK_EN adds the
// correct-answer streak counter and dp indicator.
module value_display
  import value_display_pkg::*;
#(
  parameter int BLINK_CYCLES = 2_500_000,
  parameter bit COMMON_ANODE = 1'b0,
  parameter int STREAK_THRESH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] streak
);
  logic [3:0] value_q;
  logic [1:0] state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [6:0] seg_q, seg_d, glyph;
  logic entry, wrap;
  seg_glyph_rom u_rom (.code(value), .glyph(glyph));
  assign entry = value != value_q;
  assign wrap = cnt_q == 24'(BLINK_CYCLES - 1);
  always_comb begin
    state_d = entry ? (is_result(value) ? ST_RES_ON : ST_SHOW)
            : state_q == ST_SHOW ? ST_SHOW
            : wrap ? (state_q == ST_RES_ON ? ST_RES_OFF : ST_RES_ON)
            : state_q;
    cnt_d = (entry || state_q == ST_SHOW || wrap) ? 24'd0 : cnt_q + 24'd1;
    seg_d = (state_d == ST_RES_OFF ? GLYPH_BLANK : glyph) ^ {7{COMMON_ANODE}};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= 4'hF;
      state_q <= ST_SHOW;
      cnt_q <= '0;
      seg_q <= {7{COMMON_ANODE}};
    end else begin
      value_q <= value;
      state_q <= state_d;
      cnt_q <= cnt_d;
      seg_q <= seg_d;
    end
  end
  assign seg = seg_q;
`ifdef VALUE_DISPLAY_STREAK_EN
  logic [3:0] streak_q, streak_d;
  logic dp_q, dp_d;
  always_comb begin
    streak_d = !entry ? streak_q
             : value == CODE_CORRECT ? (streak_q == 4'd9 ? 4'd9 : streak_q + 4'd1)
             : value == CODE_WRONG ? 4'd0
             : streak_q;
    dp_d = (int'({28'd0, streak_d}) >= STREAK_THRESH) ^ COMMON_ANODE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q <= '0;
      dp_q <= COMMON_ANODE;
    end else begin
      streak_q <= streak_d;
      dp_q <= dp_d;
    end
  end
  assign streak = streak_q;
  assign dp = dp_q;
`else
  assign streak = '0;
  assign dp = COMMON_ANODE;
`endif
endmodule

// File: tb/tb_value_display.sv
// tb_value_display: checks value_display (common cathode and common anode) against a blink/streak model.
module tb_value_display;
  localparam int BC = 4;
`ifdef VALUE_DISPLAY_STREAK_EN
  localparam bit STREAK_EN = 1'b1;
`else
  localparam bit STREAK_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] value = 4'd0;
  logic [6:0] seg0, seg1;
  logic dp0, dp1;
  logic [3:0] streak0, streak1;
  int checks = 0;
  int errors = 0;
  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h3E, 7'h79, 7'h00, 7'h00, 7'h00, 7'h00};
  logic [3:0] m_prev = 4'hF;
  int m_since = 0;
  int m_streak = 0;
  logic [6:0] m_seg = 7'h00;
  logic [6:0] m_seg_ca;
  logic m_dp;
  logic [3:0] m_streak_out;

  value_display #(.BLINK_CYCLES(BC), .COMMON_ANODE(1'b0), .STREAK_THRESH(3)) dut0 (
    .clk(clk), .reset(reset), .value(value), .seg(seg0), .dp(dp0), .streak(streak0));
  value_display #(.BLINK_CYCLES(BC), .COMMON_ANODE(1'b1), .STREAK_THRESH(3)) dut1 (
    .clk(clk), .reset(reset), .value(value), .seg(seg1), .dp(dp1), .streak(streak1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  // Results blink by elapsed time since the entry; any change of code is a fresh entry.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_prev = 4'hF;
      m_since = 0;
      m_streak = 0;
      m_seg = 7'h00;
    end else begin
      if (value != m_prev) begin
        m_prev = value;
        m_since = 0;
        if (value == 4'd10) m_streak = m_streak < 9 ? m_streak + 1 : 9;
        else if (value == 4'd11) m_streak = 0;
      end else m_since++;
      m_seg = ((value == 4'd10 || value == 4'd11) && (m_since / BC) % 2 == 1) ? 7'h00 : glyph_tab[value];
    end
  end
  assign m_seg_ca = m_seg ^ 7'h7F;
  assign m_dp = STREAK_EN && m_streak >= 3;
  assign m_streak_out = STREAK_EN ? 4'(m_streak) : 4'd0;

  always @(negedge clk) begin
    chk("model_seg", {1'b0, seg0}, {1'b0, m_seg});
    chk("model_seg_ca", {1'b0, seg1}, {1'b0, m_seg_ca});
    chk("model_dp", {7'd0, dp0}, {7'd0, m_dp});
    chk("model_dp_ca", {7'd0, dp1}, {7'd0, ~m_dp});
    chk("model_streak", {4'd0, streak0}, {4'd0, m_streak_out});
    chk("model_streak_ca", {4'd0, streak1}, {4'd0, m_streak_out});
  end

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_seg", {1'b0, seg0}, 8'h00);
    chk("rst_seg_ca", {1'b0, seg1}, 8'h7F);
    chk("rst_dp_ca", {7'd0, dp1}, 8'h01);
    reset = 1'b0;
    @(negedge clk);
    chk("first_seg", {1'b0, seg0}, 8'h3F);
    chk("first_seg_ca", {1'b0, seg1}, 8'h40);
    value = 4'd10;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("blink10", {1'b0, seg0}, ((i / 4) % 2 == 0) ? 8'h3E : 8'h00);
    end
    value = 4'd5;
    @(negedge clk);
    value = 4'd10;
    @(negedge clk);
    repeat (6) @(negedge clk);
    chk("res_off_c6", {1'b0, seg0}, 8'h00);
    value = 4'd11;
    @(negedge clk);
    chk("switch_11", {1'b0, seg0}, 8'h79);
    repeat (3) @(negedge clk);
    chk("switch_11_on3", {1'b0, seg0}, 8'h79);
    @(negedge clk);
    chk("switch_11_off", {1'b0, seg0}, 8'h00);
`ifdef VALUE_DISPLAY_STREAK_EN
    begin
      logic [3:0] codes [5] = '{4'd10, 4'd5, 4'd10, 4'd5, 4'd10};
      logic [3:0] exp_s [5] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3};
      logic exp_d [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
        value = codes[i];
        @(negedge clk);
        chk("streak_seq", {4'd0, streak0}, {4'd0, exp_s[i]});
        chk("dp_seq", {7'd0, dp0}, {7'd0, exp_d[i]});
      end
      value = 4'd11;
      @(negedge clk);
      chk("streak_wrong", {4'd0, streak0}, 8'h00);
      chk("dp_wrong", {7'd0, dp0}, 8'h00);
    end
`endif
    value = 4'd3;
    @(negedge clk);
    value = 4'd11;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midblink_rst_seg", {1'b0, seg0}, 8'h00);
    chk("midblink_rst_seg_ca", {1'b0, seg1}, 8'h7F);
    chk("midblink_rst_streak", {4'd0, streak0}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_79", {1'b0, seg0}, 8'h79);
    repeat (3) @(negedge clk);
    chk("post_rst_on3", {1'b0, seg0}, 8'h79);
    @(negedge clk);
    chk("post_rst_off", {1'b0, seg0}, 8'h00);
    for (int i = 0; i < 11; i++) begin
      value = 4'd10;
      @(negedge clk);
      value = 4'd4;
      @(negedge clk);
    end
`ifdef VALUE_DISPLAY_STREAK_EN
    chk("streak_sat", {4'd0, streak0}, 8'h09);
    chk("dp_sat", {7'd0, dp0}, 8'h01);
`endif
    value = 4'd15;
    repeat (5) @(negedge clk);
    chk("blank15", {1'b0, seg0}, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
